pipelined_adder: RTL and testbench

- Parametrised, pipelined successor to the team's 4-bit ripple full adder.
- Adds or subtracts two WIDTH-bit operands. The carry chain is split across STAGES register stages, one WIDTH/STAGES-bit chunk per stage.
- Valid/ready handshakes on the input and output sides, with status flags on the output.
- Used as the ALU add/sub datapath building block and as a timing-closure option for wide adders.

---
 rtl/pipelined_adder.sv | 122 ++++++++++++
 tb/tb_pipelined_adder.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit with valid/ready handshakes on both sides.
// The carry chain is cut into STAGES chunks of CW bits; stage k adds chunk k
// and registers it. Operands ride along so later stages find their chunks,
// and lower sum chunks ride along so all chunks of a beat leave together.
// The whole pipe advances in lock-step; bubbles are not collapsed.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned CW   = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    // Per-stage registered state
    logic             vld_q [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];
    logic             ovf_q;
    logic             zero_q;

    // What each stage loads on an advance
    logic             src_v [STAGES];
    logic [WIDTH-1:0] src_a [STAGES];
    logic [WIDTH-1:0] src_b [STAGES];
    logic [WIDTH-1:0] src_s [STAGES];
    logic             src_c [STAGES];
    logic [CW:0]      chunk [STAGES];
    logic [WIDTH-1:0] nxt_s [STAGES];
    logic             nxt_c [STAGES];

    logic adv;
    logic ovf_d;
    logic zero_d;

    // A full output register blocks every stage, so one enable serves all.
    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv;
    assign out_valid = vld_q[LAST];
    assign sum       = s_q[LAST];
    assign carry_out = c_q[LAST];
    assign overflow  = ovf_q;
    assign zero      = zero_q;

    // Stage sources: conditioned operands for stage 0, previous stage otherwise
    always_comb begin
        src_v[0] = in_valid;
        src_a[0] = data_a;
        src_b[0] = sub ? ~data_b : data_b;
        src_s[0] = '0;
        src_c[0] = sub | carry_in;
        for (int unsigned k = 1; k < STAGES; k++) begin
            src_v[k] = vld_q[k-1];
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = s_q[k-1];
            src_c[k] = c_q[k-1];
        end
    end

    // Chunk adders: stage k fills in sum bits [k*CW +: CW] and its chunk carry
    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            chunk[k] = {1'b0, src_a[k][k*CW +: CW]} + {1'b0, src_b[k][k*CW +: CW]}
                     + {{CW{1'b0}}, src_c[k]};
            nxt_s[k] = src_s[k];
            nxt_s[k][k*CW +: CW] = chunk[k][CW-1:0];
            nxt_c[k] = chunk[k][CW];
        end
    end

    // Flags are derived from the complete sum entering the final stage
    assign ovf_d  = (src_a[LAST][WIDTH-1] == src_b[LAST][WIDTH-1]) &
                    (nxt_s[LAST][WIDTH-1] != src_a[LAST][WIDTH-1]);
    assign zero_d = ~|nxt_s[LAST];

    // Pipeline registers; data only loads with a valid beat so outputs stay quiet
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                vld_q[k] <= src_v[k];
                if (src_v[k]) begin
                    a_q[k] <= src_a[k];
                    b_q[k] <= src_b[k];
                    s_q[k] <= nxt_s[k];
                    c_q[k] <= nxt_c[k];
                end
            end
            if (src_v[LAST]) begin
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed vectors on an 8-bit/2-stage instance,
// backpressure and mid-flight reset sequences, and random add/sub streams on
// 32-bit instances with 1, 4 and 8 stages against a plain integer model.
module tb_pipelined_adder;

    localparam int S8     = 2;
    localparam int NBEATS = 1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // 8-bit, 2-stage instance
    logic       d8_in_valid, d8_in_ready, d8_sub, d8_cin;
    logic       d8_out_valid, d8_out_ready, d8_cout, d8_ovf, d8_zero;
    logic [7:0] d8_a, d8_b, d8_sum;

    pipelined_adder #(.WIDTH(8), .STAGES(2)) u_dut8 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (d8_in_valid),
        .in_ready (d8_in_ready),
        .sub      (d8_sub),
        .carry_in (d8_cin),
        .data_a   (d8_a),
        .data_b   (d8_b),
        .out_valid(d8_out_valid),
        .out_ready(d8_out_ready),
        .sum      (d8_sum),
        .carry_out(d8_cout),
        .overflow (d8_ovf),
        .zero     (d8_zero)
    );

    // 32-bit instances with 1, 4 and 8 stages
    logic        sw_in_valid [3];
    logic        sw_in_ready [3];
    logic        sw_sub      [3];
    logic        sw_cin      [3];
    logic        sw_out_valid[3];
    logic        sw_out_ready[3];
    logic        sw_cout     [3];
    logic        sw_ovf      [3];
    logic        sw_zero     [3];
    logic [31:0] sw_a        [3];
    logic [31:0] sw_b        [3];
    logic [31:0] sw_sum      [3];

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int unsigned ST = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
        pipelined_adder #(.WIDTH(32), .STAGES(ST)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (sw_in_valid[g]),
            .in_ready (sw_in_ready[g]),
            .sub      (sw_sub[g]),
            .carry_in (sw_cin[g]),
            .data_a   (sw_a[g]),
            .data_b   (sw_b[g]),
            .out_valid(sw_out_valid[g]),
            .out_ready(sw_out_ready[g]),
            .sum      (sw_sum[g]),
            .carry_out(sw_cout[g]),
            .overflow (sw_ovf[g]),
            .zero     (sw_zero[g])
        );
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        logic       zero;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [34:0] pk8();
        return {24'b0, d8_cout, d8_ovf, d8_zero, d8_sum};
    endfunction

    // Reference: {carry_out, overflow, zero, sum}
    function automatic logic [34:0] ref32(input logic [31:0] a, input logic [31:0] b,
                                          input logic sub, input logic cin);
        logic [31:0] be;
        logic [32:0] full;
        logic        ovf;
        be   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + {32'b0, (sub ? 1'b1 : cin)};
        ovf  = (a[31] == be[31]) && (full[31] != a[31]);
        return {full[32], ovf, (full[31:0] == 32'd0), full[31:0]};
    endfunction

    // Send one beat into the idle 8-bit pipe and check result and latency
    task automatic run_vec(input vec_t v, input string name);
        logic [34:0] exp;
        int          lat;
        bit          got;
        exp          = {24'b0, v.cout, v.ovf, v.zero, v.sum};
        d8_a         = v.a;
        d8_b         = v.b;
        d8_sub       = v.sub;
        d8_cin       = v.cin;
        d8_in_valid  = 1'b1;
        d8_out_ready = 1'b1;
        @(negedge clk);
        check({name, "_in_ready"}, 35'(d8_in_ready), 35'(1));
        @(posedge clk); #1;
        d8_in_valid = 1'b0;
        lat = 1;
        got = 1'b0;
        while (!got && lat <= 10) begin
            @(negedge clk);
            if (d8_out_valid) begin
                got = 1'b1;
                check(name, pk8(), exp);
                check({name, "_latency"}, 35'(lat), 35'(S8));
            end
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_seen"}, 35'(got), 35'(1));
    endtask

    // Random stream with random backpressure; first 40 cycles unstalled
    task automatic run_sweep(input int idx, input int stages);
        logic [34:0] q   [$];
        int          acc [$];
        int          recv;
        int          sent;
        int          cyc;
        logic [34:0] act;
        string       tag;
        recv = 0;
        sent = 0;
        cyc  = 0;
        tag  = $sformatf("sweep_s%0d", stages);
        @(negedge clk);
        check({tag, "_idle_valid"}, 35'(sw_out_valid[idx]), 35'(0));
        @(posedge clk); #1;
        while (recv < NBEATS && cyc < 20000) begin
            sw_in_valid[idx]  = (sent < NBEATS) && (cyc < 40 || $urandom_range(0, 3) != 0);
            sw_a[idx]         = $urandom;
            sw_b[idx]         = $urandom;
            sw_sub[idx]       = 1'($urandom_range(0, 1));
            sw_cin[idx]       = 1'($urandom_range(0, 1));
            sw_out_ready[idx] = (cyc < 40) || ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (sw_out_valid[idx]) begin
                act = {sw_cout[idx], sw_ovf[idx], sw_zero[idx], sw_sum[idx]};
                if (q.size() == 0) begin
                    check({tag, "_spurious"}, 35'(sw_out_valid[idx]), 35'(0));
                end else begin
                    check({tag, "_result"}, act, q[0]);
                    if (sw_out_ready[idx]) begin
                        if (cyc < 40)
                            check({tag, "_latency"}, 35'(cyc - acc[0]), 35'(stages));
                        void'(q.pop_front());
                        void'(acc.pop_front());
                        recv++;
                    end
                end
            end
            if (sw_in_valid[idx] && sw_in_ready[idx]) begin
                q.push_back(ref32(sw_a[idx], sw_b[idx], sw_sub[idx], sw_cin[idx]));
                acc.push_back(cyc);
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_received"}, 35'(recv), 35'(NBEATS));
        sw_in_valid[idx]  = 1'b0;
        sw_out_ready[idx] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check({tag, "_drained"}, 35'(sw_out_valid[idx]), 35'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int got;
        vec_t v;

        vecs[0] = '{8'h01, 8'h03, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{8'hFF, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{8'h7F, 8'hFF, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};

        rst          = 1'b1;
        d8_in_valid  = 1'b0;
        d8_out_ready = 1'b0;
        d8_sub       = 1'b0;
        d8_cin       = 1'b0;
        d8_a         = '0;
        d8_b         = '0;
        for (int i = 0; i < 3; i++) begin
            sw_in_valid[i]  = 1'b0;
            sw_out_ready[i] = 1'b0;
            sw_sub[i]       = 1'b0;
            sw_cin[i]       = 1'b0;
            sw_a[i]         = '0;
            sw_b[i]         = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset_out_valid", 35'(d8_out_valid), 35'(0));
        check("reset_in_ready", 35'(d8_in_ready), 35'(1));
        check("reset_outputs", pk8(), 35'(0));
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: 4 beats, output stalled in cycles 2..4
        sent = 0;
        got  = 0;
        for (int c = 0; c < 30 && got < 4; c++) begin
            d8_out_ready = !(c >= 2 && c < 5);
            d8_in_valid  = (sent < 4);
            d8_a         = 8'(sent + 1);
            d8_b         = 8'(sent + 1);
            d8_sub       = 1'b0;
            d8_cin       = 1'b0;
            @(negedge clk);
            if (c >= 2 && c < 5) begin
                check("bp_stall_valid", 35'(d8_out_valid), 35'(1));
                check("bp_stall_hold", 35'(d8_sum), 35'(8'h02));
                check("bp_stall_in_ready", 35'(d8_in_ready), 35'(0));
            end
            if (d8_out_valid && d8_out_ready) begin
                check("bp_order", 35'(d8_sum), 35'((got + 1) * 2));
                got++;
            end
            if (d8_in_valid && d8_in_ready) sent++;
            @(posedge clk); #1;
        end
        check("bp_count", 35'(got), 35'(4));
        d8_in_valid  = 1'b0;
        d8_out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_no_dup", 35'(d8_out_valid), 35'(0));
            @(posedge clk); #1;
        end

        // Reset with two beats in flight
        d8_in_valid  = 1'b1;
        d8_out_ready = 1'b1;
        d8_a         = 8'h11;
        d8_b         = 8'h22;
        @(negedge clk);
        @(posedge clk); #1;
        d8_a = 8'h33;
        d8_b = 8'h44;
        @(negedge clk);
        @(posedge clk); #1;
        rst          = 1'b1;
        d8_a         = 8'h55;
        d8_out_ready = 1'b0;
        @(negedge clk);
        check("rst_pre_valid", 35'(d8_out_valid), 35'(1));
        @(posedge clk); #1;
        rst          = 1'b0;
        d8_in_valid  = 1'b0;
        d8_out_ready = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", 35'(d8_out_valid), 35'(0));
        check("rst_mid_outputs", pk8(), 35'(0));
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("rst_no_stale", 35'(d8_out_valid), 35'(0));
        end
        @(posedge clk); #1;
        v = '{8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0};
        run_vec(v, "rst_new_beat");

        // Parameter sweep
        run_sweep(0, 1);
        run_sweep(1, 4);
        run_sweep(2, 8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
